// File: rtl/mux2_sel_arbiter_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mux2_sel_arbiter_pkg : state encoding and mux select constants for the arbiter
// Revision: 1.0
// ----------------------------------------------------------------------------
package mux2_sel_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'b001,
    ST_G0   = 3'b010,
    ST_G1   = 3'b100
  } arb_state_e;

  localparam logic SEL_I0 = 1'b0;
  localparam logic SEL_I1 = 1'b1;

  function automatic logic sel_for(input arb_state_e st, input logic cur);
    case (st)
      ST_G0:   sel_for = SEL_I0;
      ST_G1:   sel_for = SEL_I1;
      default: sel_for = cur;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/mux2_sel_arbiter_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mux2_sel_arbiter_if : request/grant/select bundle between requesters and arbiter
// Revision: 1.0
// ----------------------------------------------------------------------------
interface mux2_sel_arbiter_if;
  logic req0;
  logic req1;
  logic gnt0;
  logic gnt1;
  logic s0;
  logic busy;

  modport master (
    output req0,
    output req1,
    input  gnt0,
    input  gnt1,
    input  s0,
    input  busy
  );

  modport slave (
    input  req0,
    input  req1,
    output gnt0,
    output gnt1,
    output s0,
    output busy
  );
endinterface
`default_nettype wire

// File: rtl/mux2_hold_counter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mux2_hold_counter : saturating grant-length counter with hold-limit comparator
// Revision: 1.0
// ----------------------------------------------------------------------------
module mux2_hold_counter #(
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 3
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             clr_i,
  input  wire logic             inc_i,
  output logic [CNT_W-1:0]      cnt_o,
  output logic                  hit_o
);

  localparam logic [CNT_W-1:0] C_HIT_VAL = CNT_W'(HOLD_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic             hit;

  assign hit   = (cnt_q == C_HIT_VAL);
  assign cnt_o = cnt_q;
  assign hit_o = hit;

  // Saturates at the limit so a lone requester can hold the grant forever.
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      cnt_q <= '0;
    end else if (inc_i && !hit) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/mux2_sel_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mux2_sel_arbiter : registered round-robin arbiter driving the 2:1 mux select
// Revision: 1.0
// ----------------------------------------------------------------------------
module mux2_sel_arbiter #(
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 3
) (
  input wire logic           clk,
  input wire logic           rst,
  mux2_sel_arbiter_if.slave  arb
);

  import mux2_sel_arbiter_pkg::*;

  arb_state_e       state_q;
  arb_state_e       state_d;
  logic             last_gnt_q;
  logic             gnt0_q;
  logic             gnt1_q;
  logic             s0_q;
  logic             busy_q;
  logic [CNT_W-1:0] cnt;
  logic             hit;
  logic             cnt_inc;
  logic             cnt_clr;

  always_comb begin
    state_d = ST_IDLE;
    case (state_q)
      ST_IDLE: begin
        if (arb.req0 && arb.req1) state_d = last_gnt_q ? ST_G0 : ST_G1;
        else if (arb.req0)        state_d = ST_G0;
        else if (arb.req1)        state_d = ST_G1;
        else                      state_d = ST_IDLE;
      end
      ST_G0: begin
        if (!arb.req0)                state_d = arb.req1 ? ST_G1 : ST_IDLE;
        else if (arb.req1 && hit)     state_d = ST_G1;
        else                          state_d = ST_G0;
      end
      ST_G1: begin
        if (!arb.req1)                state_d = arb.req0 ? ST_G0 : ST_IDLE;
        else if (arb.req0 && hit)     state_d = ST_G0;
        else                          state_d = ST_G1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The counter only runs while a grant is kept; any entry or idle clears it.
  assign cnt_inc = (state_d == state_q) && (state_q != ST_IDLE);
  assign cnt_clr = !cnt_inc;

  mux2_hold_counter #(
    .HOLD_CYCLES (HOLD_CYCLES),
    .CNT_W       (CNT_W)
  ) u_hold_counter (
    .clk   (clk),
    .rst   (rst),
    .clr_i (cnt_clr),
    .inc_i (cnt_inc),
    .cnt_o (cnt),
    .hit_o (hit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      last_gnt_q <= 1'b1;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      s0_q       <= SEL_I0;
      busy_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt0_q  <= (state_d == ST_G0);
      gnt1_q  <= (state_d == ST_G1);
      busy_q  <= (state_d == ST_G0) || (state_d == ST_G1);
      // Select holds its value while idle so the mux output stays put.
      s0_q    <= sel_for(state_d, s0_q);
      if (state_d == ST_G0) last_gnt_q <= 1'b0;
      if (state_d == ST_G1) last_gnt_q <= 1'b1;
    end
  end

  assign arb.gnt0 = gnt0_q;
  assign arb.gnt1 = gnt1_q;
  assign arb.s0   = s0_q;
  assign arb.busy = busy_q;

  logic unused_cnt;
  assign unused_cnt = ^cnt;

endmodule
`default_nettype wire

// File: tb/tb_mux2_sel_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_mux2_sel_arbiter : scoreboard bench with directed scenarios and random requests
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_mux2_sel_arbiter;

  localparam int HOLD = 4;

  typedef struct packed {
    logic g0;
    logic g1;
    logic busy;
    logic s0;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic i0  = 1'b0;
  logic i1  = 1'b1;
  logic mux_out;

  int checks   = 0;
  int failures = 0;
  exp_t q[$];

  // Reference: who owns the mux, how long they have held it, who had it last.
  int   own  = -1;
  int   run  = 0;
  int   last = 1;
  logic sel  = 1'b0;

  mux2_sel_arbiter_if arb ();

  mux2_sel_arbiter #(.HOLD_CYCLES(HOLD), .CNT_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .arb (arb)
  );

  assign mux_out = arb.s0 ? i1 : i0;

  always #5 clk = ~clk;

  function automatic void grant(input int k);
    own  = k;
    run  = 1;
    last = k;
    sel  = (k == 1);
  endfunction

  function automatic void model(input logic r0, input logic r1, input logic rs);
    logic mine, oth;
    if (rs) begin
      own = -1; run = 0; last = 1; sel = 1'b0;
    end else if (own < 0) begin
      if (r0 && r1)  grant(last == 1 ? 0 : 1);
      else if (r0)   grant(0);
      else if (r1)   grant(1);
    end else begin
      mine = (own == 0) ? r0 : r1;
      oth  = (own == 0) ? r1 : r0;
      if (!mine) begin
        if (oth) grant(1 - own);
        else     own = -1;
      end else if (oth && run >= HOLD) begin
        grant(1 - own);
      end else begin
        run++;
      end
    end
  endfunction

  task automatic step(input logic r0, input logic r1, input logic rs);
    exp_t e;
    arb.req0 = r0;
    arb.req1 = r1;
    rst      = rs;
    model(r0, r1, rs);
    e.g0   = (own == 0);
    e.g1   = (own == 1);
    e.busy = (own >= 0);
    e.s0   = sel;
    @(posedge clk);
    q.push_back(e);
    #1;
  endtask

  task automatic chk(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, req);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("gnt0", arb.gnt0, e.g0);
        chk("gnt1", arb.gnt1, e.g1);
        chk("busy", arb.busy, e.busy);
        chk("s0", arb.s0, e.s0);
        chk("mux_out", mux_out, e.s0 ? i1 : i0);
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : stim
    arb.req0 = 1'b0;
    arb.req1 = 1'b0;
    #1;
    // Reset, then idle
    repeat (2) step(1'b0, 1'b0, 1'b1);
    repeat (5) step(1'b0, 1'b0, 1'b0);
    // Lone requester holds beyond the hold limit, then releases
    repeat (10) step(1'b1, 1'b0, 1'b0);
    repeat (2) step(1'b0, 1'b0, 1'b0);
    // Contention from reset: alternating bursts of HOLD cycles
    repeat (2) step(1'b1, 1'b1, 1'b1);
    repeat (20) step(1'b1, 1'b1, 1'b0);
    // Ride into G1, then drop req1 for a bubble-free handoff to source 0
    while (own != 1) step(1'b1, 1'b1, 1'b0);
    repeat (2) step(1'b0, 1'b1, 1'b0);
    repeat (3) step(1'b1, 1'b0, 1'b0);
    // Reset in the middle of a G1 grant with both still requesting
    repeat (3) step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    repeat (6) step(1'b1, 1'b1, 1'b0);
    // Lone hold saturates, then contention must rotate on the next edge
    repeat (12) step(1'b0, 1'b1, 1'b0);
    repeat (3) step(1'b1, 1'b1, 1'b0);
    // Random traffic with occasional resets, biased toward sticky requests
    for (int i = 0; i < 600; i++) begin
      logic r0, r1, rs;
      r0 = ($urandom_range(0, 3) != 0);
      r1 = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) == 0) begin
        r0 = 1'b0;
        r1 = 1'b0;
      end
      rs = ($urandom_range(0, 63) == 0);
      step(r0, r1, rs);
    end
    step(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expected entries left, required 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
